// File: rtl/jzjpcc_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W core.
// Tracks the destinations of the instructions in E, M and W. Drives the
// decode-stage forwarding selects and the load-use stall, the post-redirect
// flush and the whole-pipeline freeze while data memory is busy.
//
// Decode handshake: dValid marks a valid instruction in D. The instruction is
// accepted into E on a rising edge only when dValid=1, stallFD=0, flushFD=0
// and freeze=0. While stallFD=1 the front end must hold the same instruction
// in D and present it again on the next cycle.
module jzjpcc_pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter bit FWD_ENABLE   = 1'b1
) (
  input  logic       clock,
  input  logic       not_reset,
  input  logic       dValid,
  input  logic [4:0] dRs1Addr,
  input  logic [4:0] dRs2Addr,
  input  logic       dRs1Used,
  input  logic       dRs2Used,
  input  logic [4:0] dRdAddr,
  input  logic       dRdWriteEn,
  input  logic       dIsLoad,
  input  logic       exRedirect,
  input  logic       memBusy,
  output logic       stallFD,
  output logic       bubbleE,
  output logic       flushFD,
  output logic       freeze,
  output logic [1:0] rs1FwdSel,
  output logic [1:0] rs2FwdSel,
  output logic [4:0] dbgState
);

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

  // Tracker slots. W keeps no load flag: once an instruction has left M its
  // result is available for forwarding whether or not it was a load.
  slot_t      e_q, m_q;
  slot_t      e_d;
  logic       w_we_q;
  logic [4:0] w_rd_q;

  state_t     state_q;
  logic [3:0] cnt_q;

  logic e_m1, e_m2, m_m1, m_m2, w_m1, w_m2;
  logic load_use, any_match, hazard, flush_act;

  function automatic logic slot_match(input logic we, input logic [4:0] rd,
                                      input logic [4:0] addr, input logic used,
                                      input logic valid);
    return valid && used && we && (rd != 5'd0) && (rd == addr);
  endfunction

  // RAW match of each in-flight slot against both decode source registers.
  always_comb begin
    e_m1      = slot_match(e_q.we, e_q.rd, dRs1Addr, dRs1Used, dValid);
    e_m2      = slot_match(e_q.we, e_q.rd, dRs2Addr, dRs2Used, dValid);
    m_m1      = slot_match(m_q.we, m_q.rd, dRs1Addr, dRs1Used, dValid);
    m_m2      = slot_match(m_q.we, m_q.rd, dRs2Addr, dRs2Used, dValid);
    w_m1      = slot_match(w_we_q, w_rd_q, dRs1Addr, dRs1Used, dValid);
    w_m2      = slot_match(w_we_q, w_rd_q, dRs2Addr, dRs2Used, dValid);
    load_use  = e_q.ld && (e_m1 || e_m2);
    any_match = e_m1 || e_m2 || m_m1 || m_m2 || w_m1 || w_m2;
    hazard    = FWD_ENABLE ? load_use : any_match;
    flush_act = (state_q == ST_FLUSH) || exRedirect;
  end

  // Control outputs: memBusy beats flush, flush beats the hazard stall.
  always_comb begin
    stallFD   = 1'b0;
    bubbleE   = 1'b0;
    flushFD   = 1'b0;
    freeze    = 1'b0;
    rs1FwdSel = 2'd0;
    rs2FwdSel = 2'd0;
    if (not_reset) begin
      if (memBusy) begin
        freeze  = 1'b1;
        stallFD = 1'b1;
      end else if (flush_act) begin
        flushFD = 1'b1;
      end else if (hazard) begin
        stallFD = 1'b1;
        bubbleE = 1'b1;
      end
      // A load in E has no result yet, so it never selects the E path.
      if (FWD_ENABLE) begin
        if (e_m1 && !e_q.ld) rs1FwdSel = 2'd1;
        else if (m_m1)       rs1FwdSel = 2'd2;
        else if (w_m1)       rs1FwdSel = 2'd3;
        if (e_m2 && !e_q.ld) rs2FwdSel = 2'd1;
        else if (m_m2)       rs2FwdSel = 2'd2;
        else if (w_m2)       rs2FwdSel = 2'd3;
      end
    end
  end

  // Entry offered to E: the decode instruction, or a bubble when it is held.
  always_comb begin
    e_d = '0;
    if (dValid && !hazard && !flush_act) begin
      e_d.we = dRdWriteEn;
      e_d.rd = dRdAddr;
      e_d.ld = dIsLoad;
    end
  end

  // Slot shift E -> M -> W on every non-frozen edge.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_we_q <= 1'b0;
      w_rd_q <= 5'd0;
    end else if (!memBusy) begin
      e_q    <= e_d;
      m_q    <= e_q;
      w_we_q <= m_q.we;
      w_rd_q <= m_q.rd;
    end
  end

  // Redirect FSM: counts the flush cycles that follow the redirect cycle.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else if (!memBusy) begin
      case (state_q)
        ST_RUN: begin
          if (exRedirect && (FLUSH_CYCLES > 1)) begin
            state_q <= ST_FLUSH;
            cnt_q   <= RELOAD;
          end
        end
        ST_FLUSH: begin
          if (exRedirect) begin
            cnt_q <= RELOAD;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign dbgState = {logic'(state_q), cnt_q};

endmodule

// File: tb/tb_jzjpcc_pipeline_ctrl.sv
// Bench for jzjpcc_pipeline_ctrl: one forwarding and one non-forwarding
// instance share the same directed decode stream. A queue-based model of the
// in-flight instructions predicts every output of both on each falling edge;
// literal expectations in the directed sequence pin the model.
module tb_jzjpcc_pipeline_ctrl;
  localparam int FC = 2;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  typedef struct packed {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       freeze;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       lu1;
    logic       lu2;
  } exp_t;

  // Clock/reset and stimulus signals
  logic       clock = 1'b0;
  logic       not_reset;
  logic       dValid, dRs1Used, dRs2Used, dRdWriteEn, dIsLoad;
  logic [4:0] dRs1Addr, dRs2Addr, dRdAddr;
  logic       exRedirect, memBusy;

  logic       f_stall, f_bubble, f_flush, f_freeze;
  logic [1:0] f_s1, f_s2;
  logic [4:0] f_dbg;
  logic       n_stall, n_bubble, n_flush, n_freeze;
  logic [1:0] n_s1, n_s2;
  logic [4:0] n_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: index 0 is the youngest instruction (E), 2 the oldest (W).
  ent_t h0[$];
  ent_t h1[$];
  int   fr0, fr1;
  exp_t e0, e1;
  ent_t ne;

  always #5 clock = ~clock;

  jzjpcc_pipeline_ctrl #(.FLUSH_CYCLES(FC), .FWD_ENABLE(1'b1)) u_fwd (
    .clock(clock), .not_reset(not_reset), .dValid(dValid),
    .dRs1Addr(dRs1Addr), .dRs2Addr(dRs2Addr), .dRs1Used(dRs1Used),
    .dRs2Used(dRs2Used), .dRdAddr(dRdAddr), .dRdWriteEn(dRdWriteEn),
    .dIsLoad(dIsLoad), .exRedirect(exRedirect), .memBusy(memBusy),
    .stallFD(f_stall), .bubbleE(f_bubble), .flushFD(f_flush),
    .freeze(f_freeze), .rs1FwdSel(f_s1), .rs2FwdSel(f_s2), .dbgState(f_dbg)
  );

  jzjpcc_pipeline_ctrl #(.FLUSH_CYCLES(FC), .FWD_ENABLE(1'b0)) u_nofwd (
    .clock(clock), .not_reset(not_reset), .dValid(dValid),
    .dRs1Addr(dRs1Addr), .dRs2Addr(dRs2Addr), .dRs1Used(dRs1Used),
    .dRs2Used(dRs2Used), .dRdAddr(dRdAddr), .dRdWriteEn(dRdWriteEn),
    .dIsLoad(dIsLoad), .exRedirect(exRedirect), .memBusy(memBusy),
    .stallFD(n_stall), .bubbleE(n_bubble), .flushFD(n_flush),
    .freeze(n_freeze), .rs1FwdSel(n_s1), .rs2FwdSel(n_s2), .dbgState(n_dbg)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input logic [7:0] act, input logic [7:0] bad);
    n_cmp++;
    if (act === bad) begin
      n_bad++;
      $display("FAIL %s: got %0d, must not be %0d (t=%0t)", name, act, bad, $time);
    end
  endtask

  // Outputs implied by the rules, from the in-flight list and decode inputs.
  function automatic exp_t model(input bit fwd, input ent_t h[$], input int frem);
    exp_t r;
    logic m1 [3];
    logic m2 [3];
    logic any_m, haz;
    r     = '0;
    any_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m1[k] = dValid && dRs1Used && h[k].we && (h[k].rd != 0) && (h[k].rd == dRs1Addr);
      m2[k] = dValid && dRs2Used && h[k].we && (h[k].rd != 0) && (h[k].rd == dRs2Addr);
      any_m = any_m || m1[k] || m2[k];
    end
    r.lu1 = fwd && h[0].ld && m1[0];
    r.lu2 = fwd && h[0].ld && m2[0];
    haz   = fwd ? (r.lu1 || r.lu2) : any_m;
    if (memBusy) begin
      r.freeze = 1'b1;
      r.stall  = 1'b1;
    end else if (exRedirect || frem > 0) begin
      r.flush = 1'b1;
    end else if (haz) begin
      r.stall  = 1'b1;
      r.bubble = 1'b1;
    end
    if (fwd) begin
      for (int k = 2; k >= 0; k--) begin
        if (m1[k]) r.s1 = 2'(k + 1);
        if (m2[k]) r.s2 = 2'(k + 1);
      end
    end
    return r;
  endfunction

  task automatic cmp_inst(input string tag, input exp_t e, input logic st, input logic bb,
                          input logic fl, input logic fz, input logic [1:0] a1,
                          input logic [1:0] a2);
    chk({tag, ".stallFD"}, 8'(st), 8'(e.stall));
    chk({tag, ".bubbleE"}, 8'(bb), 8'(e.bubble));
    chk({tag, ".flushFD"}, 8'(fl), 8'(e.flush));
    chk({tag, ".freeze"},  8'(fz), 8'(e.freeze));
    if (e.lu1) chk_ne({tag, ".rs1FwdSel_loadE"}, 8'(a1), 8'd1);
    else       chk({tag, ".rs1FwdSel"}, 8'(a1), 8'(e.s1));
    if (e.lu2) chk_ne({tag, ".rs2FwdSel_loadE"}, 8'(a2), 8'd1);
    else       chk({tag, ".rs2FwdSel"}, 8'(a2), 8'(e.s2));
  endtask

  task automatic model_reset();
    h0.delete();
    h1.delete();
    repeat (3) begin
      h0.push_back('0);
      h1.push_back('0);
    end
    fr0 = 0;
    fr1 = 0;
  endtask

  // Scoreboard: compare both instances on every falling edge, then advance.
  always @(negedge clock) begin
    if (!not_reset) begin
      cmp_inst("rst_fwd", '0, f_stall, f_bubble, f_flush, f_freeze, f_s1, f_s2);
      cmp_inst("rst_nofwd", '0, n_stall, n_bubble, n_flush, n_freeze, n_s1, n_s2);
      model_reset();
    end else begin
      e0 = model(1'b1, h0, fr0);
      e1 = model(1'b0, h1, fr1);
      cmp_inst("fwd", e0, f_stall, f_bubble, f_flush, f_freeze, f_s1, f_s2);
      cmp_inst("nofwd", e1, n_stall, n_bubble, n_flush, n_freeze, n_s1, n_s2);
      if (!memBusy) begin
        ne = (dValid && !e0.stall && !e0.flush) ? {dRdWriteEn, dRdAddr, dIsLoad} : '0;
        h0.push_front(ne);
        void'(h0.pop_back());
        ne = (dValid && !e1.stall && !e1.flush) ? {dRdWriteEn, dRdAddr, dIsLoad} : '0;
        h1.push_front(ne);
        void'(h1.pop_back());
        fr0 = exRedirect ? FC - 1 : (fr0 > 0 ? fr0 - 1 : 0);
        fr1 = exRedirect ? FC - 1 : (fr1 > 0 ? fr1 - 1 : 0);
      end
    end
  end

  // Driver tasks
  task automatic set_i(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2);
    dValid     = v;
    dRdAddr    = rd;
    dRdWriteEn = we;
    dIsLoad    = ld;
    dRs1Addr   = r1;
    dRs1Used   = u1;
    dRs2Addr   = r2;
    dRs2Used   = u2;
  endtask

  task automatic nop();
    set_i(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) step();
  endtask

  initial begin
    model_reset();
    // Reset holds every output low even with busy/redirect/match present
    not_reset  = 1'b0;
    memBusy    = 1'b1;
    exRedirect = 1'b1;
    set_i(1'b1, 5'd1, 1'b1, 1'b0, 5'd1, 1'b1, 5'd1, 1'b1);
    #2;
    chk("reset.freeze", 8'(f_freeze), 8'd0);
    chk("reset.stallFD", 8'(f_stall), 8'd0);
    chk("reset.flushFD", 8'(n_flush), 8'd0);
    step();
    memBusy    = 1'b0;
    exRedirect = 1'b0;
    nop();
    step();
    not_reset = 1'b1;
    #1;
    chk("reset.dbgState", 8'(f_dbg), 8'd0);
    step();

    // Back-to-back dependency: select walks 1 -> 2 -> 3
    set_i(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0);
    step();
    set_i(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
    #1;
    chk("b2b.rs1FwdSel_E", 8'(f_s1), 8'd1);
    chk("b2b.rs2FwdSel_E", 8'(f_s2), 8'd1);
    chk("b2b.stallFD", 8'(f_stall), 8'd0);
    chk("b2b.nofwd_stallFD", 8'(n_stall), 8'd1);
    chk("b2b.nofwd_rs1FwdSel", 8'(n_s1), 8'd0);
    step();
    set_i(1'b1, 5'd8, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("b2b.rs1FwdSel_M", 8'(f_s1), 8'd2);
    step();
    set_i(1'b1, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("b2b.rs1FwdSel_W", 8'(f_s1), 8'd3);
    step();
    drain();

    // Load-use: one stall cycle, then forward from M
    set_i(1'b1, 5'd7, 1'b1, 1'b1, 5'd1, 1'b0, 5'd2, 1'b0);
    step();
    set_i(1'b1, 5'd10, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu.stallFD", 8'(f_stall), 8'd1);
    chk("lu.bubbleE", 8'(f_bubble), 8'd1);
    step();
    #1;
    chk("lu.stallFD_after", 8'(f_stall), 8'd0);
    chk("lu.rs1FwdSel_M", 8'(f_s1), 8'd2);
    step();
    drain();

    // x0 is never a forwarding source
    set_i(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0);
    step();
    set_i(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("x0.rs1FwdSel", 8'(f_s1), 8'd0);
    chk("x0.rs2FwdSel", 8'(f_s2), 8'd0);
    chk("x0.stallFD", 8'(f_stall), 8'd0);
    chk("x0.nofwd_stallFD", 8'(n_stall), 8'd0);
    step();
    drain();

    // Redirect: flush for FC cycles, then re-redirect inside the flush
    set_i(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    exRedirect = 1'b1;
    #1;
    chk("redir.flushFD_0", 8'(f_flush), 8'd1);
    chk("redir.stallFD", 8'(f_stall), 8'd0);
    chk("redir.bubbleE", 8'(f_bubble), 8'd0);
    step();
    exRedirect = 1'b0;
    #1;
    chk("redir.flushFD_1", 8'(f_flush), 8'd1);
    step();
    nop();
    #1;
    chk("redir.flushFD_end", 8'(f_flush), 8'd0);
    step();
    set_i(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    exRedirect = 1'b1;
    step();
    #1;
    chk("redir2.flushFD_1", 8'(f_flush), 8'd1);
    step();
    exRedirect = 1'b0;
    #1;
    chk("redir2.flushFD_ext", 8'(f_flush), 8'd1);
    step();
    set_i(1'b1, 5'd12, 1'b1, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
    #1;
    chk("redir2.flushFD_end", 8'(f_flush), 8'd0);
    chk("redir2.squashed_rs1FwdSel", 8'(f_s1), 8'd0);
    step();
    drain();

    // memBusy freeze with the producer in M; redirect while frozen is ignored
    set_i(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    nop();
    step();
    set_i(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
    memBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exRedirect = (i == 1);
      #1;
      chk("busy.freeze", 8'(f_freeze), 8'd1);
      chk("busy.stallFD", 8'(f_stall), 8'd1);
      chk("busy.bubbleE", 8'(f_bubble), 8'd0);
      chk("busy.flushFD", 8'(f_flush), 8'd0);
      chk("busy.rs1FwdSel", 8'(f_s1), 8'd2);
      step();
    end
    exRedirect = 1'b0;
    memBusy    = 1'b0;
    #1;
    chk("busy.release_freeze", 8'(f_freeze), 8'd0);
    chk("busy.release_flushFD", 8'(f_flush), 8'd0);
    chk("busy.release_rs1FwdSel", 8'(f_s1), 8'd2);
    step();
    #1;
    chk("busy.advanced_rs1FwdSel", 8'(f_s1), 8'd3);
    step();
    drain();

    // Reset during a flush with a load in E
    set_i(1'b1, 5'd14, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_i(1'b1, 5'd15, 1'b1, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
    exRedirect = 1'b1;
    #1;
    chk("rstflush.flushFD", 8'(f_flush), 8'd1);
    chk("rstflush.stallFD", 8'(f_stall), 8'd0);
    not_reset = 1'b0;
    #1;
    chk("rstflush.flushFD_rst", 8'(f_flush), 8'd0);
    chk("rstflush.stallFD_rst", 8'(f_stall), 8'd0);
    chk("rstflush.bubbleE_rst", 8'(f_bubble), 8'd0);
    chk("rstflush.rs1FwdSel_rst", 8'(f_s1), 8'd0);
    exRedirect = 1'b0;
    step();
    not_reset = 1'b1;
    #1;
    chk("rstflush.flushFD_after", 8'(f_flush), 8'd0);
    chk("rstflush.stallFD_after", 8'(f_stall), 8'd0);
    chk("rstflush.dbgState_after", 8'(f_dbg), 8'd0);
    step();
    #1;
    chk("rstflush.flushFD_next", 8'(f_flush), 8'd0);
    step();
    drain();

    // Non-forwarding instance: stall until the producer leaves W
    set_i(1'b1, 5'd16, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_i(1'b1, 5'd17, 1'b1, 1'b0, 5'd16, 1'b1, 5'd16, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nofwd.stallFD", 8'(n_stall), 8'd1);
      chk("nofwd.bubbleE", 8'(n_bubble), 8'd1);
      chk("nofwd.rs1FwdSel", 8'(n_s1), 8'd0);
      chk("nofwd.rs2FwdSel", 8'(n_s2), 8'd0);
      step();
    end
    #1;
    chk("nofwd.stallFD_done", 8'(n_stall), 8'd0);
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jzjpcc_pipeline_ctrl.md
Name: jzjpcc_pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined core: F, D, E, M, W.
- Tracks destination registers of the in-flight instructions in E, M and W.
- Drives operand-forwarding selects for the decode-stage regfile reads (rs1/rs2).
- Generates load-use stalls, post-redirect flushes and whole-pipeline freeze on memory busy. Sits beside the regfile and PC, steering both.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flushFD is held after a taken redirect (range 1-15).
- FWD_ENABLE, 1, 1 = forward from E/M/W; 0 = stall on any E/M/W RAW match instead.

Ports:
- clock  in  1  system clock, rising edge
- not_reset  in  1  asynchronous, active-low reset
- dValid  in  1  decode stage holds a valid instruction
- dRs1Addr  in  5  decode rs1 address
- dRs2Addr  in  5  decode rs2 address
- dRs1Used  in  1  instruction reads rs1
- dRs2Used  in  1  instruction reads rs2
- dRdAddr  in  5  decode destination address
- dRdWriteEn  in  1  instruction writes rd
- dIsLoad  in  1  instruction is a load
- exRedirect  in  1  branch/jump taken, resolved in E
- memBusy  in  1  data memory not ready; pipeline must freeze
- stallFD  out  1  hold PC and F/D registers
- bubbleE  out  1  insert NOP into E
- flushFD  out  1  squash F and D contents
- freeze  out  1  hold all pipeline registers
- rs1FwdSel  out  2  0 regfile, 1 E result, 2 M result, 3 W result
- rs2FwdSel  out  2  same encoding for rs2

Behaviour:
- Tracker: three registered slots, E, M and W, each holding {we, rd[4:0], isLoad}. A slot with we=0 is a bubble.
- Reset (not_reset low, async): all slots become bubbles; FSM goes to RUN; flush counter = 0. All outputs read 0 combinationally while in reset.
- Match rule: a slot matches rsN when slot.we=1, slot.rd != 0, slot.rd == dRsNAddr, dRsNUsed=1 and dValid=1. Register x0 never matches.
- Forward select: priority is youngest first, E > M > W; otherwise 0. Outputs are combinational from slots and decode inputs, with zero latency.
- Load-use: if the E slot is a load and matches either rs, then stallFD=1 and bubbleE=1. A load in E never produces a select of 1. Same-cycle select is don't-care; the stall re-evaluates next cycle, when the load is in M and the select is 2.
- FWD_ENABLE=0: any match in E, M or W gives stallFD=1 and bubbleE=1. Selects stay 0.
- Advance (each clock edge with memBusy=0): M to W, E to M. E receives the decode entry only if dValid=1, stallFD=0 and flushFD=0; otherwise E receives a bubble.
- FSM states:
  - RUN: if exRedirect=1, then flushFD=1 this cycle. Go to FLUSH with counter = FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1.
  - FLUSH: flushFD=1, counter decrements each advancing cycle, return to RUN after the cycle in which counter==1. exRedirect in FLUSH reloads the counter to FLUSH_CYCLES-1.
- Priority: memBusy > flush > stall.
  - With memBusy=1: freeze=1, stallFD=1, bubbleE=0, flushFD=0. Slots, FSM and counter hold. exRedirect is ignored; E is frozen, so it is re-presented after memBusy drops.
  - With flush active: stallFD=0 and bubbleE=0; the decode entry is discarded as a bubble.
- Async reset mid-flush or mid-freeze: immediate return to RUN with empty slots. No residual flush follows.

Test Plan:
- Back-to-back ADD x5 then ADD x6,x5,x5 -> cycle 2: rs1FwdSel=1, rs2FwdSel=1, stallFD=0. One cycle later with an unrelated instruction reading x5: select=2. Two cycles later: select=3.
- LW x7, then a consumer of x7 -> exactly 1 cycle of stallFD=1/bubbleE=1, then rs1FwdSel=2, no further stall.
- Write to x0 followed by a reader of x0 -> selects stay 0, no stall.
- exRedirect for 1 cycle with FLUSH_CYCLES=2 -> flushFD high for exactly 2 cycles, E receives 2 bubbles. A second exRedirect during FLUSH extends flushFD to 2 cycles from that point.
- memBusy held 3 cycles while a matching instruction sits in M -> freeze=1 and select stays 2 throughout. Slots unchanged. After release, the instruction advances and the select becomes 3.
- not_reset pulsed low during FLUSH with E holding a load -> all outputs 0 immediately. After release, no stall and no flush occurs.
- FWD_ENABLE=0 with dependent ADDs -> stallFD for 3 cycles until the producer leaves W. Selects stay 0.
